// File: rtl/mul_pkg.sv
// ---------------------------------------------------------------------------
// mul_pkg
// Shared definitions for the iterative shift-add multiplier.
//   state_t     : controller states (IDLE, RUN, FINISH)
//   MULT/MULTU  : ALU function codes; the decoder drives is_signed high for
//                 MULT and low for MULTU.
// ---------------------------------------------------------------------------
package mul_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    RUN    = 2'd1,
    FINISH = 2'd2
  } state_t;

  localparam logic [5:0] MULT  = 6'b011000;
  localparam logic [5:0] MULTU = 6'b011001;

endpackage

// File: rtl/seq_multiplier_if.sv
// ---------------------------------------------------------------------------
// seq_multiplier_if
// Request/response bundle between the ALU control and the multiplier.
//   start      : request pulse, accepted only when the multiplier is free
//   is_signed  : 1 = MULT (two's complement), 0 = MULTU
//   op_a/op_b  : operands, sampled together with start
//   busy       : high while iterating
//   done       : one-cycle pulse when product updates
//   product    : {HI,LO} result register
// master = ALU control side, slave = multiplier side.
// ---------------------------------------------------------------------------
interface seq_multiplier_if
  import mul_pkg::*;
#(
  parameter int WIDTH = 32
);

  logic                 start;
  logic                 is_signed;
  logic [WIDTH-1:0]     op_a;
  logic [WIDTH-1:0]     op_b;
  logic                 busy;
  logic                 done;
  logic [2*WIDTH-1:0]   product;

  modport master (
    output start, is_signed, op_a, op_b,
    input  busy, done, product
  );

  modport slave (
    input  start, is_signed, op_a, op_b,
    output busy, done, product
  );

endinterface

// File: rtl/mul_sign_fix.sv
// ---------------------------------------------------------------------------
// mul_sign_fix
// Combinational sign handling around the unsigned shift-add core.
//   i_isSigned        : operands are two's complement
//   i_opA/i_opB       : raw operands
//   o_magA/o_magB     : operand magnitudes (unsigned, WIDTH bits)
//   o_neg             : the true product is negative
//   i_negate/i_raw    : unsigned product and whether to negate it
//   o_product         : final 2*WIDTH-bit product
// ---------------------------------------------------------------------------
module mul_sign_fix
  import mul_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic               i_isSigned,
  input  logic [WIDTH-1:0]   i_opA,
  input  logic [WIDTH-1:0]   i_opB,
  output logic [WIDTH-1:0]   o_magA,
  output logic [WIDTH-1:0]   o_magB,
  output logic               o_neg,
  input  logic               i_negate,
  input  logic [2*WIDTH-1:0] i_raw,
  output logic [2*WIDTH-1:0] o_product
);

  logic w_negA;
  logic w_negB;

  assign w_negA = i_isSigned & i_opA[WIDTH-1];
  assign w_negB = i_isSigned & i_opB[WIDTH-1];

  // Negating the most negative value wraps back to the same bit pattern,
  // which read as unsigned is exactly 2^(WIDTH-1), the correct magnitude.
  assign o_magA = w_negA ? ((~i_opA) + WIDTH'(1)) : i_opA;
  assign o_magB = w_negB ? ((~i_opB) + WIDTH'(1)) : i_opB;
  assign o_neg  = w_negA ^ w_negB;

  // A zero magnitude product negates to zero, so 0 * negative stays 0.
  assign o_product = i_negate ? ((~i_raw) + (2*WIDTH)'(1)) : i_raw;

endmodule

// File: rtl/seq_multiplier.sv
// ---------------------------------------------------------------------------
// seq_multiplier
// Iterative shift-add multiplier for MULT/MULTU. One multiplier bit is
// consumed per RUN cycle; the product register and done pulse update on the
// edge that leaves FINISH, WIDTH+1 edges after start was sampled.
//   clk    : clock, rising edge
//   reset  : synchronous, active-high; aborts any operation in progress
//   bus    : seq_multiplier_if slave (start/is_signed/op_a/op_b in,
//            busy/done/product out)
// ---------------------------------------------------------------------------
module seq_multiplier
  import mul_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic            clk,
  input  logic            reset,
  seq_multiplier_if.slave bus
);

  localparam int CNT_W = $clog2(WIDTH + 1);

  state_t               r_state;
  state_t               w_nextState;
  logic [CNT_W-1:0]     r_cnt;
  logic [WIDTH-1:0]     r_magA;
  logic [WIDTH-1:0]     r_mplier;
  logic                 r_neg;
  logic [2*WIDTH:0]     r_acc;
  logic [2*WIDTH-1:0]   r_product;
  logic                 r_done;

  logic                 w_busy;
  logic                 w_accept;
  logic [WIDTH-1:0]     w_magA;
  logic [WIDTH-1:0]     w_magB;
  logic                 w_neg;
  logic [2*WIDTH-1:0]   w_fixed;
  logic [WIDTH:0]       w_addend;
  logic [WIDTH:0]       w_sum;
  logic [2*WIDTH:0]     w_accNext;

  mul_sign_fix #(
    .WIDTH (WIDTH)
  ) u_signFix (
    .i_isSigned (bus.is_signed),
    .i_opA      (bus.op_a),
    .i_opB      (bus.op_b),
    .o_magA     (w_magA),
    .o_magB     (w_magB),
    .o_neg      (w_neg),
    .i_negate   (r_neg),
    .i_raw      (r_acc[2*WIDTH-1:0]),
    .o_product  (w_fixed)
  );

  // One iteration: add the multiplicand into the upper half (including the
  // carry bit) when the current multiplier bit is set, then shift the whole
  // accumulator right. The carry lands in bit 2*WIDTH-1 and the top bit
  // becomes zero, so the next addition can never overflow WIDTH+1 bits.
  assign w_addend  = r_mplier[0] ? {1'b0, r_magA} : '0;
  assign w_sum     = r_acc[2*WIDTH:WIDTH] + w_addend;
  assign w_accNext = {1'b0, w_sum, r_acc[WIDTH-1:1]};

  // State register.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_nextState;
    end
  end

  // Next-state and control decode. FINISH accepts a new start just like
  // IDLE so operations can be issued back to back.
  always_comb begin
    w_nextState = r_state;
    w_busy      = 1'b0;
    w_accept    = 1'b0;
    case (r_state)
      IDLE: begin
        w_accept = bus.start;
        if (bus.start) begin
          w_nextState = RUN;
        end
      end
      RUN: begin
        w_busy = 1'b1;
        if (r_cnt == CNT_W'(1)) begin
          w_nextState = FINISH;
        end
      end
      FINISH: begin
        w_accept    = bus.start;
        w_nextState = bus.start ? RUN : IDLE;
      end
      default: begin
        w_nextState = IDLE;
      end
    endcase
  end

  // Datapath. Product is only written when leaving FINISH, so an aborted
  // run never leaks a partial result. In a back-to-back FINISH the product
  // is taken from the old accumulator before the new operands load.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_cnt     <= '0;
      r_magA    <= '0;
      r_mplier  <= '0;
      r_neg     <= 1'b0;
      r_acc     <= '0;
      r_product <= '0;
      r_done    <= 1'b0;
    end else begin
      r_done <= 1'b0;
      if (r_state == FINISH) begin
        r_product <= w_fixed;
        r_done    <= 1'b1;
      end
      if (w_accept) begin
        r_magA   <= w_magA;
        r_mplier <= w_magB;
        r_neg    <= w_neg;
        r_acc    <= '0;
        r_cnt    <= CNT_W'(WIDTH);
      end else if (r_state == RUN) begin
        r_acc    <= w_accNext;
        r_mplier <= {1'b0, r_mplier[WIDTH-1:1]};
        r_cnt    <= r_cnt - CNT_W'(1);
      end
    end
  end

  assign bus.busy    = w_busy;
  assign bus.done    = r_done;
  assign bus.product = r_product;

endmodule

// File: tb/tb_seq_multiplier.sv
// ---------------------------------------------------------------------------
// tb_seq_multiplier
// Directed bench for a 32-bit and an 8-bit seq_multiplier sharing one clock
// and reset. Inputs are driven and outputs sampled on the falling edge.
// ---------------------------------------------------------------------------
module tb_seq_multiplier;

  logic clk = 1'b0;
  logic reset;

  always #5 clk = ~clk;

  seq_multiplier_if #(.WIDTH(32)) bus32 ();
  seq_multiplier_if #(.WIDTH(8))  bus8 ();

  seq_multiplier #(.WIDTH(32)) dut32 (
    .clk   (clk),
    .reset (reset),
    .bus   (bus32)
  );

  seq_multiplier #(.WIDTH(8)) dut8 (
    .clk   (clk),
    .reset (reset),
    .bus   (bus8)
  );

  int compared   = 0;
  int mismatched = 0;

  // Single comparison point: counts and reports on mismatch.
  task automatic checkOutput(input string tag, input logic [63:0] observed,
                             input logic [63:0] expected);
    compared++;
    assert (observed === expected) else begin
      mismatched++;
      $error("[TB] FAIL %s: observed=0x%h expected=0x%h", tag, observed, expected);
    end
  endtask

  // Issue one 32-bit operation from a falling edge and wait (bounded) for
  // done. lat counts rising edges after the start edge; -1 means no done.
  task automatic applyStimulus(input logic [31:0] a, input logic [31:0] b,
                               input logic s, output int lat, output int busyCnt,
                               output logic [63:0] prod, output logic busyAtDone);
    bus32.start     = 1'b1;
    bus32.op_a      = a;
    bus32.op_b      = b;
    bus32.is_signed = s;
    @(negedge clk);
    bus32.start = 1'b0;
    lat         = -1;
    prod        = '0;
    busyAtDone  = 1'b1;
    busyCnt     = bus32.busy ? 1 : 0;
    for (int k = 1; k <= 60; k++) begin
      @(negedge clk);
      if (bus32.done) begin
        lat        = k;
        prod       = bus32.product;
        busyAtDone = bus32.busy;
        break;
      end
      if (bus32.busy) busyCnt++;
    end
  endtask

  task automatic applyStimulusNarrow(input logic [7:0] a, input logic [7:0] b,
                                     input logic s, output int lat,
                                     output logic [15:0] prod);
    bus8.start     = 1'b1;
    bus8.op_a      = a;
    bus8.op_b      = b;
    bus8.is_signed = s;
    @(negedge clk);
    bus8.start = 1'b0;
    lat        = -1;
    prod       = '0;
    for (int k = 1; k <= 30; k++) begin
      @(negedge clk);
      if (bus8.done) begin
        lat  = k;
        prod = bus8.product;
        break;
      end
    end
  endtask

  initial begin
    int          lat;
    int          busyCnt;
    logic [63:0] prod;
    logic        busyAtDone;
    logic [15:0] prod8;
    int          doneCnt;
    int          firstK;
    int          secondK;
    logic [63:0] firstProd;
    logic [63:0] secondProd;
    logic        prevDone;
    int          backToBack;

    bus32.start = 1'b0; bus32.is_signed = 1'b0; bus32.op_a = '0; bus32.op_b = '0;
    bus8.start  = 1'b0; bus8.is_signed  = 1'b0; bus8.op_a  = '0; bus8.op_b  = '0;
    reset = 1'b1;
    repeat (2) @(negedge clk);
    checkOutput("reset_busy",    64'(bus32.busy),    64'd0);
    checkOutput("reset_done",    64'(bus32.done),    64'd0);
    checkOutput("reset_product", bus32.product,      64'd0);
    reset = 1'b0;
    @(negedge clk);

    $display("[TB] unsigned max * max");
    applyStimulus(32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0, lat, busyCnt, prod, busyAtDone);
    checkOutput("umax_product", prod, 64'hFFFF_FFFE_0000_0001);
    checkOutput("umax_latency", 64'(lat), 64'd33);
    checkOutput("umax_busy_cycles", 64'(busyCnt), 64'd32);
    checkOutput("umax_busy_at_done", 64'(busyAtDone), 64'd0);

    $display("[TB] signed and unsigned -3 * 7");
    applyStimulus(32'hFFFF_FFFD, 32'd7, 1'b1, lat, busyCnt, prod, busyAtDone);
    checkOutput("s_m3x7", prod, 64'hFFFF_FFFF_FFFF_FFEB);
    applyStimulus(32'hFFFF_FFFD, 32'd7, 1'b0, lat, busyCnt, prod, busyAtDone);
    checkOutput("u_m3x7", prod, 64'h0000_0006_FFFF_FFEB);

    $display("[TB] most negative operands");
    applyStimulus(32'h8000_0000, 32'h8000_0000, 1'b1, lat, busyCnt, prod, busyAtDone);
    checkOutput("s_min_x_min", prod, 64'h4000_0000_0000_0000);
    applyStimulus(32'h8000_0000, 32'd1, 1'b1, lat, busyCnt, prod, busyAtDone);
    checkOutput("s_min_x_1", prod, 64'hFFFF_FFFF_8000_0000);
    applyStimulus(32'd0, 32'hFFFF_FFFB, 1'b1, lat, busyCnt, prod, busyAtDone);
    checkOutput("s_0_x_m5", prod, 64'd0);

    $display("[TB] disturbance during run and back-to-back start");
    bus32.start = 1'b1; bus32.op_a = 32'd5; bus32.op_b = 32'd6; bus32.is_signed = 1'b0;
    @(negedge clk);
    bus32.start = 1'b1; bus32.op_a = 32'd9; bus32.op_b = 32'd9;
    doneCnt = 0; firstK = -1; secondK = -1; firstProd = '0; secondProd = '0;
    prevDone = 1'b0; backToBack = 0;
    for (int k = 1; k <= 80; k++) begin
      @(negedge clk);
      if (bus32.done) begin
        doneCnt++;
        if (prevDone) backToBack++;
        if (firstK < 0) begin
          firstK = k; firstProd = bus32.product;
        end else if (secondK < 0) begin
          secondK = k; secondProd = bus32.product;
        end
      end
      prevDone = bus32.done;
      if (k < 32) begin
        bus32.start     = (k == 10);
        bus32.op_a      = $urandom;
        bus32.op_b      = $urandom;
        bus32.is_signed = (k % 2 == 1);
      end else if (k == 32) begin
        bus32.start     = 1'b1;
        bus32.op_a      = 32'd9;
        bus32.op_b      = 32'd9;
        bus32.is_signed = 1'b0;
      end else begin
        bus32.start = 1'b0;
      end
    end
    checkOutput("dist_first_k",    64'(firstK), 64'd33);
    checkOutput("dist_first_prod", firstProd,   64'd30);
    checkOutput("b2b_second_k",    64'(secondK), 64'd66);
    checkOutput("b2b_second_prod", secondProd,  64'd81);
    checkOutput("dist_done_count", 64'(doneCnt), 64'd2);
    checkOutput("done_consecutive", 64'(backToBack), 64'd0);

    $display("[TB] reset in the middle of a run");
    bus32.start = 1'b1; bus32.op_a = 32'd7; bus32.op_b = 32'd8; bus32.is_signed = 1'b0;
    @(negedge clk);
    bus32.start = 1'b0;
    repeat (10) @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    checkOutput("abort_busy",    64'(bus32.busy), 64'd0);
    checkOutput("abort_done",    64'(bus32.done), 64'd0);
    checkOutput("abort_product", bus32.product,   64'd0);
    reset   = 1'b0;
    doneCnt = 0;
    for (int k = 0; k < 40; k++) begin
      @(negedge clk);
      if (bus32.done) doneCnt++;
    end
    checkOutput("abort_no_done", 64'(doneCnt), 64'd0);
    applyStimulus(32'd2, 32'd3, 1'b0, lat, busyCnt, prod, busyAtDone);
    checkOutput("after_abort_2x3", prod, 64'd6);

    $display("[TB] 8-bit instance");
    applyStimulusNarrow(8'h80, 8'hFF, 1'b1, lat, prod8);
    checkOutput("w8_s_min_x_m1", 64'(prod8), 64'h0080);
    applyStimulusNarrow(8'hFF, 8'hFF, 1'b0, lat, prod8);
    checkOutput("w8_umax_product", 64'(prod8), 64'hFE01);
    checkOutput("w8_umax_latency", 64'(lat), 64'd9);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
